scaler_snapshot_seq: RTL



---
 rtl/scaler_snapshot_seq_pkg.sv | 45 ++++
 rtl/scaler_snapshot_seq_if.sv | 32 +++
 rtl/scaler_snapshot_dpram.sv | 53 +++++
 rtl/scaler_snapshot_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/scaler_snapshot_seq_pkg.sv
// -----------------------------------------------------------------------------
// scaler_snapshot_seq_pkg
// Shared constants, state encoding and the word-index to scaler-address map
// for the one-second scaler snapshot sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package scaler_snapshot_seq_pkg;

    // L2/L3 words live at scaler addresses 0x00-0x1F, followed by aux words.
    localparam int NUM_MAIN  = 32;
    localparam int NUM_AUX   = 4;
    localparam int NUM_WORDS = NUM_MAIN + NUM_AUX;

    localparam int SETTLE_CYCLES_DEF = 4;

    typedef logic [5:0] word_idx_t;

    localparam word_idx_t WORD_CNT  = 6'(NUM_WORDS);
    localparam word_idx_t LAST_WORD = 6'(NUM_WORDS - 1);

    // Aux scaler addresses; the mux space between them is unused.
    localparam word_idx_t AUX_REFPULSE     = 6'h20;
    localparam word_idx_t AUX_SEC_DEADTIME = 6'h21;
    localparam word_idx_t AUX_RF           = 6'h24;
    localparam word_idx_t AUX_C3PO         = 6'h27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_SWAP
    } state_t;

    // Snapshot word index -> scaler mux address.
    function automatic word_idx_t word_to_addr(input word_idx_t w);
        case (w)
            6'd32:   return AUX_REFPULSE;
            6'd33:   return AUX_SEC_DEADTIME;
            6'd34:   return AUX_RF;
            6'd35:   return AUX_C3PO;
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/scaler_snapshot_seq_if.sv
// -----------------------------------------------------------------------------
// scaler_snapshot_seq_if
// Bus bundle between the snapshot sequencer, the scaler mux and the host
// read side.
//   scal_addr_o  6   address to the scaler mux (driven by the sequencer)
//   scal_dat_i   32  mux data, combinational from scal_addr_o
//   rd_addr_i    6   host read word index 0-35
//   rd_dat_o     32  host read data, one cycle after rd_addr_i
// Modports: master = sequencer, slave = mux model / host.
// -----------------------------------------------------------------------------
interface scaler_snapshot_seq_if;

    logic [5:0]  scal_addr_o;
    logic [31:0] scal_dat_i;
    logic [5:0]  rd_addr_i;
    logic [31:0] rd_dat_o;

    modport master (
        output scal_addr_o,
        input  scal_dat_i,
        input  rd_addr_i,
        output rd_dat_o
    );

    modport slave (
        input  scal_addr_o,
        output scal_dat_i,
        output rd_addr_i,
        input  rd_dat_o
    );

endinterface

// File: rtl/scaler_snapshot_dpram.sv
// -----------------------------------------------------------------------------
// scaler_snapshot_dpram
// Double-buffered snapshot store: 2 banks x 36 words x 32 bits, one write
// port addressed by (bank, index) and one registered read port.
//   clk33_i   in   clock
//   rst_i     in   synchronous active-high reset (read register only)
//   wr_en     in   write strobe
//   wr_bank   in   bank being filled
//   wr_idx    in   word index 0-35
//   wr_dat    in   word data
//   rd_bank   in   bank visible to the host
//   rd_valid  in   visible bank holds a completed snapshot
//   rd_idx    in   host word index; >= 36 reads as 0
//   rd_dat    out  registered read data
// -----------------------------------------------------------------------------
module scaler_snapshot_dpram
    import scaler_snapshot_seq_pkg::*;
(
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        wr_en,
    input  logic        wr_bank,
    input  word_idx_t   wr_idx,
    input  logic [31:0] wr_dat,
    input  logic        rd_bank,
    input  logic        rd_valid,
    input  word_idx_t   rd_idx,
    output logic [31:0] rd_dat
);

    logic [31:0] mem [2][NUM_WORDS];

    // NOTE: the storage array has no reset; clearing 72 words would force it
    // out of RAM/LUTRAM and nothing ever reads a word before it is written.
    always_ff @(posedge clk33_i) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_dat;
        end
    end

    // Until the first full scan after reset the visible bank may hold an
    // aborted, partial scan, so it reads as zero.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            rd_dat <= '0;
        end else if (rd_valid && (rd_idx < WORD_CNT)) begin
            rd_dat <= mem[rd_bank][rd_idx];
        end else begin
            rd_dat <= '0;
        end
    end

endmodule

// File: rtl/scaler_snapshot_seq.sv
// -----------------------------------------------------------------------------
// scaler_snapshot_seq
// On each PPS rising edge: wait SETTLE_CYCLES for the scaler holds, walk the
// scaler mux through all 36 meaningful words, store them in the back bank and
// then swap banks so the host always reads a coherent one-second snapshot.
//   clk33_i       in   33 MHz clock
//   rst_i         in   synchronous active-high reset
//   pps_i         in   PPS, synchronous to clk33_i
//   bus           --   scaler mux address/data and host read port (master)
//   snap_ready_o  out  one-cycle pulse when a new snapshot becomes visible
//   snap_count_o  out  completed snapshot count, wraps
//   busy_o        out  high from the PPS edge until the bank swap
//   missed_o      out  PPS edges seen while busy, saturates at 0xFF
// -----------------------------------------------------------------------------
module scaler_snapshot_seq
    import scaler_snapshot_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                        clk33_i,
    input  logic                        rst_i,
    input  logic                        pps_i,
    scaler_snapshot_seq_if.master       bus,
    output logic                        snap_ready_o,
    output logic [15:0]                 snap_count_o,
    output logic                        busy_o,
    output logic [7:0]                  missed_o
);

    state_t      state;
    logic        pps_q;
    logic        pps_rise;
    logic [7:0]  settle_cnt;

    // Three-stage scan pipeline: issue address, register mux data, write.
    word_idx_t   issue_idx;
    logic        addr_vld;
    word_idx_t   addr_idx;
    logic        cap_vld;
    word_idx_t   cap_idx;
    logic [31:0] cap_dat;

    logic        disp_bank;
    logic        bank_valid;

    assign pps_rise = pps_i & ~pps_q;

    // NOTE: every register here uses <= so all updates see the pre-edge
    // values; a blocking = would let later statements see half-updated state.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            pps_q           <= 1'b0;
            settle_cnt      <= '0;
            issue_idx       <= '0;
            addr_vld        <= 1'b0;
            addr_idx        <= '0;
            cap_vld         <= 1'b0;
            cap_idx         <= '0;
            cap_dat         <= '0;
            disp_bank       <= 1'b0;
            bank_valid      <= 1'b0;
            bus.scal_addr_o <= '0;
            snap_ready_o    <= 1'b0;
            snap_count_o    <= '0;
            busy_o          <= 1'b0;
            missed_o        <= '0;
        end else begin
            pps_q        <= pps_i;
            snap_ready_o <= 1'b0;

            // A PPS during a scan (including the swap cycle) is dropped.
            if (pps_rise && busy_o && (missed_o != 8'hFF)) begin
                missed_o <= missed_o + 8'd1;
            end

            // Pipeline advance; only SCAN launches new addresses.
            addr_vld <= 1'b0;
            cap_vld  <= addr_vld;
            cap_idx  <= addr_idx;
            if (addr_vld) begin
                cap_dat <= bus.scal_dat_i;
            end

            case (state)
                ST_IDLE: begin
                    if (pps_rise) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 8'(SETTLE_CYCLES - 1);
                        busy_o     <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= ST_SCAN;
                        issue_idx <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                ST_SCAN: begin
                    if (issue_idx != WORD_CNT) begin
                        bus.scal_addr_o <= word_to_addr(issue_idx);
                        addr_vld        <= 1'b1;
                        addr_idx        <= issue_idx;
                        issue_idx       <= issue_idx + 6'd1;
                    end
                    // The last word is written on this same edge.
                    if (cap_vld && (cap_idx == LAST_WORD)) begin
                        state <= ST_SWAP;
                    end
                end

                ST_SWAP: begin
                    disp_bank    <= ~disp_bank;
                    bank_valid   <= 1'b1;
                    snap_ready_o <= 1'b1;
                    snap_count_o <= snap_count_o + 16'd1;
                    busy_o       <= 1'b0;
                    state        <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // The back bank is always the one the host is not looking at.
    scaler_snapshot_dpram u_dpram (
        .clk33_i  (clk33_i),
        .rst_i    (rst_i),
        .wr_en    (cap_vld),
        .wr_bank  (~disp_bank),
        .wr_idx   (cap_idx),
        .wr_dat   (cap_dat),
        .rd_bank  (disp_bank),
        .rd_valid (bank_valid),
        .rd_idx   (bus.rd_addr_i),
        .rd_dat   (bus.rd_dat_o)
    );

endmodule
